// File: rtl/fec_channel_arbiter.sv
// fec_channel_arbiter: round-robin share of one encoder_fec port among N_CH sources.
// Optional watchdog on fec_ack enabled by defining FEC_ARB_TIMEOUT_EN.
module fec_channel_arbiter #(
   parameter int N_CH        = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [N_CH-1:0]          req,
   input  logic [N_CH*DATA_W-1:0]   data_in,
   output logic [N_CH-1:0]          ack,
   output logic                     fec_req,
   output logic [DATA_W-1:0]        fec_data,
   input  logic                     fec_ack,
   output logic                     busy,
   output logic [$clog2(N_CH)-1:0]  grant_ch,
   output logic                     timeout_err
);

   localparam int IW = $clog2(N_CH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      RELEASE
   } state_t;

   state_t              r_state;
   logic [N_CH-1:0]     r_ack;
   logic                r_fec_req;
   logic [DATA_W-1:0]   r_fec_data;
   logic                r_busy;
   logic [IW-1:0]       r_grant_ch;
   logic [IW-1:0]       r_rr_ptr;

   logic [IW-1:0]       w_sel;
   logic                w_start;
   logic [DATA_W-1:0]   w_data;
   logic [IW-1:0]       w_ptr_nxt;
   logic [N_CH-1:0]     w_onehot;
   logic                w_expire;

   function automatic logic [IW-1:0] f_wrap(input int v);
      if (v >= N_CH) return IW'(v - N_CH);
      return IW'(v);
   endfunction

   // Pick the first requester at or after rr_ptr, wrapping past N_CH-1.
   always_comb begin
      w_sel = r_rr_ptr;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[f_wrap(int'(r_rr_ptr) + i)])
            w_sel = f_wrap(int'(r_rr_ptr) + i);
      end
   end

   assign w_start   = en & (|req);
   assign w_data    = data_in[w_sel*DATA_W +: DATA_W];
   assign w_ptr_nxt = (r_grant_ch == IW'(N_CH - 1)) ? '0 : r_grant_ch + 1'b1;
   assign w_onehot  = {{(N_CH-1){1'b0}}, 1'b1} << r_grant_ch;

`ifdef FEC_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] r_cnt;
   logic          r_timeout_err;

   assign w_expire    = (r_cnt + 1'b1) == CW'(TIMEOUT_CYC);
   assign timeout_err = r_timeout_err;

   // Count cycles spent waiting for fec_ack; cleared outside WAIT_ACK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state != WAIT_ACK) begin
         r_cnt <= '0;
      end else if (!fec_ack) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // One-cycle error pulse when the watchdog, not fec_ack, ends the wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= (r_state == WAIT_ACK) & ~fec_ack & w_expire;
      end
   end
`else
   assign w_expire    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Arbitration FSM: grant, wait for the chain, pulse ack, then release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ack      <= '0;
         r_fec_req  <= 1'b0;
         r_fec_data <= '0;
         r_busy     <= 1'b0;
         r_grant_ch <= '0;
         r_rr_ptr   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_fec_data <= w_data;
                  r_grant_ch <= w_sel;
                  r_fec_req  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (fec_ack || w_expire) begin
                  r_fec_req <= 1'b0;
                  r_ack     <= w_onehot;
                  r_rr_ptr  <= w_ptr_nxt;
                  r_state   <= RELEASE;
               end
            end
            RELEASE: begin
               r_ack   <= '0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ack      = r_ack;
   assign fec_req  = r_fec_req;
   assign fec_data = r_fec_data;
   assign busy     = r_busy;
   assign grant_ch = r_grant_ch;

endmodule

// File: tb/tb_fec_channel_arbiter.sv
// tb_fec_channel_arbiter: directed plus randomized checks of the round-robin arbiter.
// Reference keeps only the round-robin pointer and per-channel words.
module tb_fec_channel_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] data_in = '0;
   logic           fec_ack = 1'b0;
   logic [N-1:0]   ack;
   logic           fec_req;
   logic [W-1:0]   fec_data;
   logic           busy;
   logic [1:0]     grant_ch;
   logic           timeout_err;

   fec_channel_arbiter #(
      .N_CH(N), .DATA_W(W), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .data_in(data_in), .ack(ack), .fec_req(fec_req),
      .fec_data(fec_data), .fec_ack(fec_ack), .busy(busy),
      .grant_ch(grant_ch), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         rr = 0;
   int         exp_gch = 0;
   int         ack_cnt [N];
   logic [7:0] wd [N];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_data();
      for (int i = 0; i < N; i++) data_in[i*W +: W] = wd[i];
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return 0;
   endfunction

   // One full transaction from an IDLE cycle with req already driven.
   task automatic run_grant(input int dly, input bit drop,
                            input bit en_flip, input bit noise,
                            input bit stray);
      int s;
      s = pick(req, rr);
      tick();
      chk("grant_req", 32'(fec_req), 1);
      chk("grant_ch", 32'(grant_ch), s);
      chk("grant_data", 32'(fec_data), 32'(wd[s]));
      chk("grant_busy", 32'(busy), 1);
      chk("grant_ack", 32'(ack), 0);
      exp_gch = s;
      for (int d = 0; d < dly; d++) begin
         if (en_flip) en = ~en;
         if (noise) req = req ^ (4'($urandom) & ~(4'b0001 << s));
         tick();
         chk("wait_req", 32'(fec_req), 1);
         chk("wait_data", 32'(fec_data), 32'(wd[s]));
         chk("wait_ack", 32'(ack), 0);
      end
      fec_ack = 1'b1;
      tick();
      fec_ack = stray;
      chk("done_req", 32'(fec_req), 0);
      chk("done_ack", 32'(ack), 32'(1) << s);
      chk("done_busy", 32'(busy), 1);
      chk("done_terr", 32'(timeout_err), 0);
      ack_cnt[s]++;
      rr = (s + 1) % N;
      if (drop) req[s] = 1'b0;
      tick();
      fec_ack = 1'b0;
      chk("rel_ack", 32'(ack), 0);
      chk("rel_busy", 32'(busy), 0);
      chk("rel_req", 32'(fec_req), 0);
      chk("rel_gch", 32'(grant_ch), s);
   endtask

   initial begin
      int seq [6];
      int s;
      int cnt;
      seq = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < N; i++) begin
         wd[i] = 8'h10 + 8'(i);
         ack_cnt[i] = 0;
      end
      load_data();

      tick();
      tick();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_req", 32'(fec_req), 0);
      chk("rst_data", 32'(fec_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_gch", 32'(grant_ch), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      rst_n = 1'b1;
      en = 1'b1;
      tick();

      req = 4'b1111;
      for (int g = 0; g < 6; g++) begin
         run_grant(2, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("t2_seq", 32'(grant_ch), seq[g]);
         if (g == 3) begin
            for (int i = 0; i < N; i++) chk("t2_fair", ack_cnt[i], 1);
         end
      end

      req = 4'b1001;
      run_grant(1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_first", 32'(grant_ch), 3);
      run_grant(1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_second", 32'(grant_ch), 0);

      wd[2] = 8'hA5;
      load_data();
      req = 4'b0100;
      run_grant(3, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t1_data", 32'(fec_data), 32'h0A5);

      en = 1'b0;
      req = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_blocked", 32'(fec_req), 0);
      end
      en = 1'b1;
      run_grant(0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_gch", 32'(grant_ch), 1);

      req = 4'b1000;
      tick();
      chk("t5_grant", 32'(grant_ch), 3);
      chk("t5_req", 32'(fec_req), 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_req", 32'(fec_req), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_gch", 32'(grant_ch), 0);
      chk("t5_rst_data", 32'(fec_data), 0);
      tick();
      chk("t5_rst_ack", 32'(ack), 0);
      rst_n = 1'b1;
      rr = 0;
      exp_gch = 0;
      req = 4'b1010;
      run_grant(1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_after", 32'(grant_ch), 1);
      req = '0;

`ifdef FEC_ARB_TIMEOUT_EN
      req = 4'b0001;
      s = pick(req, rr);
      tick();
      cnt = 0;
      for (int i = 0; i < 40 && fec_req; i++) begin
         cnt++;
         tick();
      end
      chk("t6_len", cnt, TO);
      chk("t6_req", 32'(fec_req), 0);
      chk("t6_terr", 32'(timeout_err), 1);
      chk("t6_ack", 32'(ack), 32'(1) << s);
      req = '0;
      rr = (s + 1) % N;
      exp_gch = s;
      tick();
      chk("t6_terr_end", 32'(timeout_err), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_ack_end", 32'(ack), 0);
`endif

      for (int it = 0; it < 200; it++) begin
         en = ($urandom % 4) != 0;
         req = 4'($urandom);
         if ($urandom % 4 == 0) req = '0;
         for (int i = 0; i < N; i++) wd[i] = 8'($urandom);
         load_data();
         if (en && req != 0) begin
            run_grant(int'($urandom % 6), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom));
         end else begin
            fec_ack = 1'($urandom);
            tick();
            fec_ack = 1'b0;
            chk("idle_req", 32'(fec_req), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_ack", 32'(ack), 0);
            chk("idle_gch", 32'(grant_ch), exp_gch);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
